// File: rtl/legv8_pkg.sv
// Shared constants and types for the LEGv8 fetch/decode/control sequencer.
// Optional feature macro: LEGV8_CBNZ_EN (adds CBNZ decode).
package legv8_pkg;

  // 11-bit opcodes (IR[31:21])
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  // CB-format opcodes (IR[31:24]) and B-format opcode (IR[31:26])
  localparam logic [7:0]  OP_CBZ  = 8'hB4;
  localparam logic [7:0]  OP_CBNZ = 8'hB5;
  localparam logic [5:0]  OP_B    = 6'h05;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_WAIT  = ST_WAIT,
    S_EXEC  = ST_EXEC,
    S_HALT  = ST_HALT
  } state_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_CBZ  = 2'd1,
    BR_CBNZ = 2'd2,
    BR_B    = 2'd3
  } branch_e;

  typedef struct packed {
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       reg2loc;
    branch_e    branch;
  } ctrl_t;

  // Byte offset of a CB-format branch: sext(IR[23:5]) << 2
  function automatic logic [63:0] cb_offset(input logic [31:0] ir);
    return {{43{ir[23]}}, ir[23:5], 2'b00};
  endfunction

  // Byte offset of a B-format branch: sext(IR[25:0]) << 2
  function automatic logic [63:0] b_offset(input logic [31:0] ir);
    return {{36{ir[25]}}, ir[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/legv8_main_decoder.sv
// Combinational main decoder: instruction word -> control bundle + illegal flag.
// Optional feature macro: LEGV8_CBNZ_EN (CBNZ decodes like CBZ, inverted sense).
import legv8_pkg::*;

module legv8_main_decoder (
  input  logic [31:0] ir,
  output ctrl_t       ctrl,
  output logic        illegal
);

  logic [10:0] opcode;
  assign opcode = ir[31:21];

  // Classify the word and produce its datapath controls
  always_comb begin
    ctrl    = '0;
    ctrl.branch = BR_NONE;
    illegal = 1'b0;
    if (opcode == OP_ADD || opcode == OP_SUB ||
        opcode == OP_AND || opcode == OP_ORR) begin
      ctrl.alu_op    = ALUOP_RTYPE;
      ctrl.reg_write = 1'b1;
    end else if (opcode == OP_LDUR) begin
      ctrl.alu_op     = ALUOP_ADD;
      ctrl.alu_src    = 1'b1;
      ctrl.mem_read   = 1'b1;
      ctrl.mem_to_reg = 1'b1;
      ctrl.reg_write  = 1'b1;
    end else if (opcode == OP_STUR) begin
      ctrl.alu_op    = ALUOP_ADD;
      ctrl.alu_src   = 1'b1;
      ctrl.mem_write = 1'b1;
      ctrl.reg2loc   = 1'b1;
    end else if (ir[31:24] == OP_CBZ) begin
      ctrl.alu_op  = ALUOP_PASSB;
      ctrl.reg2loc = 1'b1;
      ctrl.branch  = BR_CBZ;
`ifdef LEGV8_CBNZ_EN
    end else if (ir[31:24] == OP_CBNZ) begin
      ctrl.alu_op  = ALUOP_PASSB;
      ctrl.reg2loc = 1'b1;
      ctrl.branch  = BR_CBNZ;
`else
    end else if (ir[31:24] == OP_CBNZ) begin
      illegal = 1'b1;
`endif
    end else if (ir[31:26] == OP_B) begin
      ctrl.branch = BR_B;
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/legv8_fetch_ctrl.sv
// Multicycle fetch/decode/control sequencer: owns the FSM, PC and IR.
// Optional feature macro: LEGV8_CBNZ_EN (handled inside the decoder).
//
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | one-cycle imem_req at pc
//   WAIT  | waiting for imem_valid; zero word halts
//   EXEC  | controls driven, pc updated on exit
//   HALT  | absorbing until reset
import legv8_pkg::*;

module legv8_fetch_ctrl #(
  parameter logic [63:0] PC_RESET = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [63:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        Zero,
  output logic [1:0]  ALUOp,
  output logic [10:0] Opcode_field,
  output logic [4:0]  rd_addr_1,
  output logic [4:0]  rd_addr_2,
  output logic [4:0]  wr_addr,
  output logic [8:0]  displacement,
  output logic        ALUSrc,
  output logic        MemRead,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic [63:0] pc,
  output logic        halted,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;

  ctrl_t       ctrl;
  logic        dec_illegal;
  logic        in_exec;
  logic [63:0] pc_next;

  legv8_main_decoder u_dec (
    .ir      (ir_q),
    .ctrl    (ctrl),
    .illegal (dec_illegal)
  );

  assign in_exec = (state_q == S_EXEC);

  // Branch resolution; Zero is consumed combinationally during EXEC
  always_comb begin
    pc_next = pc_q + 64'd4;
    case (ctrl.branch)
      BR_CBZ:  if (Zero)  pc_next = pc_q + cb_offset(ir_q);
      BR_CBNZ: if (!Zero) pc_next = pc_q + cb_offset(ir_q);
      BR_B:    pc_next = pc_q + b_offset(ir_q);
      default: ;
    endcase
  end

  // Next-state, PC and IR update
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (imem_valid) begin
          if (imem_rdata == 32'h0) begin
            state_d = S_HALT;
          end else begin
            ir_d    = imem_rdata;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        pc_d    = pc_next;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RESET;
      ir_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Output drive: strobes gated to EXEC, fields follow IR
  always_comb begin
    imem_addr    = pc_q;
    imem_req     = (state_q == S_FETCH);
    pc           = pc_q;
    halted       = (state_q == S_HALT);
    illegal      = in_exec & dec_illegal;
    ALUOp        = in_exec ? ctrl.alu_op : ALUOP_ADD;
    ALUSrc       = in_exec & ctrl.alu_src;
    MemRead      = in_exec & ctrl.mem_read;
    MemtoReg     = in_exec & ctrl.mem_to_reg;
    RegWrite     = in_exec & ctrl.reg_write;
    MemWrite     = in_exec & ctrl.mem_write;
    Opcode_field = ir_q[31:21];
    displacement = ir_q[20:12];
    rd_addr_1    = ir_q[9:5];
    wr_addr      = ir_q[4:0];
    rd_addr_2    = ctrl.reg2loc ? ir_q[4:0] : ir_q[20:16];
  end

endmodule

// File: tb/tb_legv8_fetch_ctrl.sv
// Self-checking bench for legv8_fetch_ctrl; honours LEGV8_CBNZ_EN for the CBNZ case.
module tb_legv8_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [63:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_valid = 1'b0;
  logic        Zero = 1'b0;
  logic [1:0]  ALUOp;
  logic [10:0] Opcode_field;
  logic [4:0]  rd_addr_1, rd_addr_2, wr_addr;
  logic [8:0]  displacement;
  logic        ALUSrc, MemRead, MemtoReg, RegWrite, MemWrite;
  logic [63:0] pc;
  logic        halted, illegal;

  int checks = 0;
  int errors = 0;

  legv8_fetch_ctrl #(.PC_RESET(64'h0)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .Zero(Zero),
    .ALUOp(ALUOp), .Opcode_field(Opcode_field),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2), .wr_addr(wr_addr),
    .displacement(displacement),
    .ALUSrc(ALUSrc), .MemRead(MemRead), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .MemWrite(MemWrite),
    .pc(pc), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // ctl = {ALUSrc, MemRead, MemtoReg, RegWrite, MemWrite, illegal}
  typedef struct {
    logic [31:0] word;
    logic        zero;
    int          lat;
    logic [63:0] pc;
    logic [1:0]  aluop;
    logic [5:0]  ctl;
    logic [4:0]  rd2;
    logic [63:0] npc;
  } item_t;

  item_t sb[$];
  item_t prog[12];

  function automatic item_t mk(logic [31:0] w, logic z, int l, logic [63:0] p,
                               logic [1:0] a, logic [5:0] c, logic [4:0] r2,
                               logic [63:0] n);
    item_t it;
    it.word = w; it.zero = z; it.lat = l; it.pc = p;
    it.aluop = a; it.ctl = c; it.rd2 = r2; it.npc = n;
    return it;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({pc, imem_req, halted, illegal, ALUOp, ALUSrc, MemRead, MemtoReg, RegWrite, MemWrite} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: pc=%h req=%b halted=%b ill=%b aluop=%b strobes=%b%b%b%b%b expected all zero",
               pc, imem_req, halted, illegal, ALUOp, ALUSrc, MemRead, MemtoReg, RegWrite, MemWrite);
    end
    checks++;
    if ({Opcode_field, rd_addr_1, rd_addr_2, wr_addr, displacement} !== '0) begin
      errors++;
      $display("FAIL reset_fields: op=%h rd1=%0d rd2=%0d wr=%0d disp=%h expected 0",
               Opcode_field, rd_addr_1, rd_addr_2, wr_addr, displacement);
    end
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: imem_req=%b expected 0 without start", imem_req);
    end
  endtask

  // Serve one fetch; expectation goes onto the scoreboard when the word is driven
  task automatic run_instr(input item_t it);
    item_t e;
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_timeout: no imem_req within 20 cycles, expected addr %h", it.pc);
      return;
    end
    checks++;
    if (imem_addr !== it.pc) begin
      errors++;
      $display("FAIL fetch_addr: imem_addr=%h expected %h", imem_addr, it.pc);
    end
    tick();
    for (int i = 1; i < it.lat; i++) begin
      checks++;
      if ({imem_req, RegWrite, MemWrite, MemRead, ALUOp, illegal} !== '0) begin
        errors++;
        $display("FAIL wait_quiet: req=%b rw=%b mw=%b mr=%b aluop=%b ill=%b expected 0",
                 imem_req, RegWrite, MemWrite, MemRead, ALUOp, illegal);
      end
      tick();
    end
    imem_valid = 1'b1;
    imem_rdata = it.word;
    sb.push_back(it);
    tick();
    imem_valid = 1'b0;
    imem_rdata = $urandom();
    Zero = it.zero;
    #1;
    e = sb.pop_front();
    checks++;
    if ({ALUSrc, MemRead, MemtoReg, RegWrite, MemWrite, illegal} !== e.ctl || ALUOp !== e.aluop) begin
      errors++;
      $display("FAIL exec_ctrl[%h]: ctl=%b aluop=%b expected ctl=%b aluop=%b",
               e.word, {ALUSrc, MemRead, MemtoReg, RegWrite, MemWrite, illegal}, ALUOp, e.ctl, e.aluop);
    end
    checks++;
    if (Opcode_field !== e.word[31:21] || rd_addr_1 !== e.word[9:5] || wr_addr !== e.word[4:0] ||
        displacement !== e.word[20:12] || rd_addr_2 !== e.rd2) begin
      errors++;
      $display("FAIL exec_fields[%h]: op=%h rd1=%0d rd2=%0d wr=%0d disp=%h expected op=%h rd1=%0d rd2=%0d wr=%0d disp=%h",
               e.word, Opcode_field, rd_addr_1, rd_addr_2, wr_addr, displacement,
               e.word[31:21], e.word[9:5], e.rd2, e.word[4:0], e.word[20:12]);
    end
    tick();
    checks++;
    if (pc !== e.npc) begin
      errors++;
      $display("FAIL next_pc[%h]: pc=%h expected %h", e.word, pc, e.npc);
    end
    checks++;
    if ({RegWrite, MemWrite, MemRead, illegal, ALUOp} !== '0) begin
      errors++;
      $display("FAIL strobe_one_cycle[%h]: rw=%b mw=%b mr=%b ill=%b aluop=%b expected 0 after EXEC",
               e.word, RegWrite, MemWrite, MemRead, illegal, ALUOp);
    end
  endtask

  task automatic test_program();
    logic [63:0] p10;
`ifdef LEGV8_CBNZ_EN
    p10 = 64'h24;
    prog[9] = mk(32'hB5000064, 1'b0, 1, 64'h18, 2'b01, 6'b000000, 5'd4, 64'h24);
`else
    p10 = 64'h1C;
    prog[9] = mk(32'hB5000064, 1'b0, 1, 64'h18, 2'b00, 6'b000001, 5'd0, 64'h1C);
`endif
    prog[0]  = mk(32'h8B020023, 1'b1, 1, 64'h00, 2'b10, 6'b000100, 5'd2,  64'h04);
    prog[1]  = mk(32'hF85F8025, 1'b0, 2, 64'h04, 2'b00, 6'b111100, 5'd31, 64'h08);
    prog[2]  = mk(32'h14000002, 1'b0, 1, 64'h08, 2'b00, 6'b000000, 5'd0,  64'h10);
    prog[3]  = mk(32'hB4000064, 1'b1, 1, 64'h10, 2'b01, 6'b000000, 5'd4,  64'h1C);
    prog[4]  = mk(32'h17FFFFFD, 1'b0, 1, 64'h1C, 2'b00, 6'b000000, 5'd31, 64'h10);
    prog[5]  = mk(32'hB4000064, 1'b0, 1, 64'h10, 2'b01, 6'b000000, 5'd4,  64'h14);
    prog[6]  = mk(32'hFFFFFFFF, 1'b0, 1, 64'h14, 2'b00, 6'b000001, 5'd31, 64'h18);
    prog[7]  = mk(32'h14000002, 1'b1, 1, 64'h18, 2'b00, 6'b000000, 5'd0,  64'h20);
    prog[8]  = mk(32'h17FFFFFE, 1'b0, 1, 64'h20, 2'b00, 6'b000000, 5'd31, 64'h18);
    prog[10] = mk(32'hF8008061, 1'b0, 4, p10, 2'b00, 6'b100010, 5'd1, p10 + 64'd4);
    prog[11] = mk(32'hAA030041, 1'b0, 1, p10 + 64'd4, 2'b10, 6'b000100, 5'd3, p10 + 64'd8);
    start = 1'b1;
    tick();
    start = 1'b0;
    foreach (prog[i]) run_instr(prog[i]);
  endtask

  task automatic test_reset_abort();
    // Last instruction left the FSM in FETCH; move into WAIT and reset there
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (pc !== 64'h0 || imem_req !== 1'b0 || {RegWrite, MemWrite, MemRead, illegal, halted} !== '0) begin
      errors++;
      $display("FAIL reset_abort: pc=%h req=%b rw=%b mw=%b mr=%b ill=%b halted=%b expected pc=0 and all 0",
               pc, imem_req, RegWrite, MemWrite, MemRead, illegal, halted);
    end
    imem_valid = 1'b1;
    imem_rdata = 32'h8B020023;
    tick();
    imem_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_req !== 1'b0 || pc !== 64'h0 || RegWrite !== 1'b0) begin
        errors++;
        $display("FAIL late_valid_ignored: req=%b pc=%h rw=%b expected 0/0/0", imem_req, pc, RegWrite);
      end
      tick();
    end
  endtask

  task automatic test_halt();
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      errors++;
      $display("FAIL halt_fetch: req=%b addr=%h expected 1 and 0", imem_req, imem_addr);
    end
    tick();
    imem_valid = 1'b1;
    imem_rdata = 32'h0;
    tick();
    imem_valid = 1'b0;
    checks++;
    if (halted !== 1'b1 || {RegWrite, MemWrite, MemRead, illegal} !== '0) begin
      errors++;
      $display("FAIL halt_enter: halted=%b rw=%b mw=%b mr=%b ill=%b expected halted=1 strobes 0",
               halted, RegWrite, MemWrite, MemRead, illegal);
    end
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (imem_req !== 1'b0 || halted !== 1'b1 || pc !== 64'h0) begin
        errors++;
        $display("FAIL halt_absorb: req=%b halted=%b pc=%h expected 0/1/0", imem_req, halted, pc);
      end
    end
    start = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset: halted=%b expected 0", halted);
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_reset_abort();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
